// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch-operand stalls, memory freeze, watchdog.
// Optional statistics counters are built when HAZARD_CTRL_STAT_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic        exe_reg_write,
    input  logic [4:0]  exe_num_write,
    input  logic        exe_is_load,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if2id_en,
    output logic        id2exe_en,
    output logic        exe2mem_en,
    output logic        if2id_flush,
    output logic        id2exe_flush,
    output logic        mem2wb_flush,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);
    typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;

    localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       ret_br_q, ret_br_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic match, lu_hz, br_hz, br_on_load;
    logic freeze_raw, expired, freeze;

    assign match = exe_reg_write && (exe_num_write != 5'd0) &&
                   ((exe_num_write == id_rs && id_uses_rs) ||
                    (exe_num_write == id_rt && id_uses_rt));
    assign lu_hz      = exe_is_load && match;
    assign br_hz      = id_is_branch && match && !exe_is_load;
    assign br_on_load = id_is_branch && exe_is_load && match;

    // Watchdog fires only when it actually cuts short a freeze that would otherwise hold.
    assign freeze_raw = mem_req && !mem_ready;
    assign expired    = freeze_raw && (state_q == MEM_WAIT) && (wd_cnt_q == WD_LAST);
    assign freeze     = freeze_raw && !expired;

    always_comb begin
        pc_en        = 1'b1;
        if2id_en     = 1'b1;
        id2exe_en    = 1'b1;
        exe2mem_en   = 1'b1;
        if2id_flush  = 1'b0;
        id2exe_flush = 1'b0;
        mem2wb_flush = 1'b0;
        if (!reset) begin
            pc_en        = 1'b0;
            if2id_en     = 1'b0;
            id2exe_en    = 1'b0;
            exe2mem_en   = 1'b0;
            if2id_flush  = 1'b1;
            id2exe_flush = 1'b1;
            mem2wb_flush = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if2id_en     = 1'b0;
            id2exe_en    = 1'b0;
            exe2mem_en   = 1'b0;
            mem2wb_flush = 1'b1;
        end else if (state_q == BR_WAIT || lu_hz || br_hz) begin
            // Branch outcome is not trusted while stalled, so no IF/ID flush here.
            pc_en        = 1'b0;
            if2id_en     = 1'b0;
            id2exe_flush = 1'b1;
        end else if (id_branch_taken) begin
            if2id_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_br_d  = ret_br_q;
        wd_cnt_d  = freeze ? wd_cnt_q + 8'd1 : 8'd0;
        mem_err_d = mem_err_q | expired;
        if (freeze) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) ret_br_d = (state_q == BR_WAIT);
        end else begin
            case (state_q)
                RUN:      if (br_on_load) state_d = BR_WAIT;
                BR_WAIT:  state_d = RUN;
                MEM_WAIT: state_d = ret_br_q ? BR_WAIT : RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            ret_br_q  <= 1'b0;
            wd_cnt_q  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_br_q  <= ret_br_d;
            wd_cnt_q  <= wd_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;

`ifdef HAZARD_CTRL_STAT_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q + {31'd0, !pc_en};
        flush_count_d = flush_count_q + {31'd0, if2id_flush};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: single-cycle vector table plus multi-cycle stall/freeze/watchdog sequences.
module tb_hazard_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, exe_num_write;
    logic        id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
    logic        exe_reg_write, exe_is_load, mem_req, mem_ready;
    logic        pc_en, if2id_en, id2exe_en, exe2mem_en;
    logic        if2id_flush, id2exe_flush, mem2wb_flush, mem_err;
    logic [1:0]  state;
    logic [31:0] stall_count, flush_count;

    always #5 clock = ~clock;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .exe_reg_write(exe_reg_write), .exe_num_write(exe_num_write), .exe_is_load(exe_is_load),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if2id_en(if2id_en), .id2exe_en(id2exe_en), .exe2mem_en(exe2mem_en),
        .if2id_flush(if2id_flush), .id2exe_flush(id2exe_flush), .mem2wb_flush(mem2wb_flush),
        .mem_err(mem_err), .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    // {pc_en, if2id_en, id2exe_en, exe2mem_en, if2id_flush, id2exe_flush, mem2wb_flush}
    localparam logic [6:0] DEF = 7'b1111_000;
    localparam logic [6:0] STL = 7'b0011_010;
    localparam logic [6:0] TKN = 7'b1111_100;
    localparam logic [6:0] FRZ = 7'b0000_001;
    localparam logic [6:0] RST = 7'b0000_111;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, ewr;
        logic [4:0] wn;
        logic       eld, mreq, mrdy;
        logic [6:0] out;
        logic [1:0] st;
        logic       err;
    } vec_t;

    int   n_vec = 0, n_bad = 0;
    int   exp_stall = 0, exp_flush = 0;
    vec_t exp_q[$];
    vec_t tbl[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic br, input logic tk, input logic ewr,
                                input logic [4:0] wn, input logic eld, input logic mreq,
                                input logic mrdy, input logic [6:0] out, input logic [1:0] st,
                                input logic err);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.tk = tk; v.ewr = ewr;
        v.wn = wn; v.eld = eld; v.mreq = mreq; v.mrdy = mrdy; v.out = out; v.st = st; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_en, if2id_en, id2exe_en, exe2mem_en, if2id_flush, id2exe_flush, mem2wb_flush};
    endfunction

    task automatic drive_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0;
        exe_reg_write = 1'b0; exe_num_write = 5'd0; exe_is_load = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Entered at posedge+1; drives, compares at negedge, returns at the next posedge+1.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_is_branch = v.br; id_branch_taken = v.tk;
        exe_reg_write = v.ewr; exe_num_write = v.wn; exe_is_load = v.eld;
        mem_req = v.mreq; mem_ready = v.mrdy;
        exp_q.push_back(v);
        @(negedge clock);
        e = exp_q.pop_front();
        chk({nm, ".out"},   32'(outs()),  32'(e.out));
        chk({nm, ".state"}, 32'(state),   32'(e.st));
        chk({nm, ".err"},   32'(mem_err), 32'(e.err));
        if (!e.out[6]) exp_stall++;
        if (e.out[2])  exp_flush++;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stats(input string nm);
`ifdef HAZARD_CTRL_STAT_EN
        chk({nm, ".stall_count"}, stall_count, 32'(exp_stall));
        chk({nm, ".flush_count"}, flush_count, 32'(exp_flush));
`else
        chk({nm, ".stall_count"}, stall_count, 32'd0);
        chk({nm, ".flush_count"}, flush_count, 32'd0);
`endif
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".out"},   32'(outs()),  32'(RST));
        chk({nm, ".state"}, 32'(state),   32'd0);
        chk({nm, ".err"},   32'(mem_err), 32'd0);
        chk({nm, ".stall_count"}, stall_count, 32'd0);
        chk({nm, ".flush_count"}, flush_count, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    initial begin
        //            rs     rt     urs urt br tk ewr wn     eld mreq mrdy out  st     err
        tbl[0]  = mk(5'd0,  5'd0,  O,  O,  O, O, O,  5'd0,  O,  O,   O,   DEF, 2'd0, O);
        tbl[1]  = mk(5'd5,  5'd1,  I,  O,  O, O, I,  5'd5,  I,  O,   O,   STL, 2'd0, O);
        tbl[2]  = mk(5'd2,  5'd5,  I,  I,  O, O, I,  5'd5,  I,  O,   O,   STL, 2'd0, O);
        tbl[3]  = mk(5'd5,  5'd0,  O,  O,  O, O, I,  5'd5,  I,  O,   O,   DEF, 2'd0, O);
        tbl[4]  = mk(5'd0,  5'd0,  I,  I,  O, O, I,  5'd0,  I,  O,   O,   DEF, 2'd0, O);
        tbl[5]  = mk(5'd7,  5'd0,  I,  O,  O, O, I,  5'd7,  O,  O,   O,   DEF, 2'd0, O);
        tbl[6]  = mk(5'd7,  5'd3,  I,  I,  I, O, I,  5'd7,  O,  O,   O,   STL, 2'd0, O);
        tbl[7]  = mk(5'd0,  5'd0,  I,  O,  I, I, I,  5'd0,  O,  O,   O,   TKN, 2'd0, O);
        tbl[8]  = mk(5'd9,  5'd0,  I,  O,  I, I, I,  5'd9,  O,  O,   O,   STL, 2'd0, O);
        tbl[9]  = mk(5'd5,  5'd0,  I,  O,  O, O, O,  5'd5,  I,  O,   O,   DEF, 2'd0, O);
        tbl[10] = mk(5'd0,  5'd0,  O,  O,  O, O, O,  5'd0,  O,  I,   I,   DEF, 2'd0, O);
        tbl[11] = mk(5'd4,  5'd6,  O,  I,  O, I, I,  5'd6,  I,  O,   O,   STL, 2'd0, O);

        reset = 1'b0;
        drive_idle();
        #2;
        chk_reset("reset");
        release_reset();

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Load-use: exactly one bubble, then EXE holds the inserted bubble
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, O, O, STL, 2'd0, O), "lu.c1");
        step(mk(5'd5, 5'd0, I, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "lu.c2");

        // Branch on ALU result: one bubble
        step(mk(5'd3, 5'd0, I, O, I, O, I, 5'd3, O, O, O, STL, 2'd0, O), "bralu.c1");
        step(mk(5'd3, 5'd0, I, O, I, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "bralu.c2");

        // Branch on load: two bubbles, RUN -> BR_WAIT -> RUN, then resolves taken
        step(mk(5'd0, 5'd8, O, I, I, O, I, 5'd8, I, O, O, STL, 2'd0, O), "brld.c1");
        step(mk(5'd0, 5'd8, O, I, I, O, O, 5'd0, O, O, O, STL, 2'd1, O), "brld.c2");
        step(mk(5'd0, 5'd8, O, I, I, I, O, 5'd0, O, O, O, TKN, 2'd0, O), "brld.c3");

        // Memory wait: three frozen cycles, ready on the fourth
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd0, O), "mw.c1");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd2, O), "mw.c2");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd2, O), "mw.c3");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, I, DEF, 2'd2, O), "mw.c4");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "mw.c5");

        // Memory wait with a load-use hazard pending: stall only once the freeze lifts
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, I, O, FRZ, 2'd0, O), "mwh.c1");
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, I, O, FRZ, 2'd2, O), "mwh.c2");
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, I, O, FRZ, 2'd2, O), "mwh.c3");
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, I, I, STL, 2'd2, O), "mwh.c4");
        step(mk(5'd5, 5'd0, I, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "mwh.c5");

        // Watchdog (timeout 4): freeze releases after three cycles, error is sticky
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd0, O), "wd.c1");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd2, O), "wd.c2");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd2, O), "wd.c3");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, DEF, 2'd2, O), "wd.c4");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, I), "wd.c5");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, I), "wd.c6");
        chk_stats("stats");

        reset = 1'b0;
        #1;
        chk_reset("wdrst");
        release_reset();
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "wdrst.after");

        // Asynchronous reset in the middle of MEM_WAIT
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd0, O), "arst.c1");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, I, O, FRZ, 2'd2, O), "arst.c2");
        #2;
        reset = 1'b0;
        #1;
        chk_reset("arst");
        drive_idle();
        release_reset();
        step(mk(5'd5, 5'd0, I, O, O, O, I, 5'd5, I, O, O, STL, 2'd0, O), "arst.lu");
        step(mk(5'd0, 5'd0, O, O, O, O, O, 5'd0, O, O, O, DEF, 2'd0, O), "arst.idle");
        chk_stats("arst.stats");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
